// File: rtl/word_pack_ctrl.sv
// Byte-to-word sequencer in front of a serial-to-parallel deserializer.
// It gates bytes in, pads partial words on idle timeout or flush, and holds each word for a valid/ready handshake.
module word_pack_ctrl #(
  parameter int                 S_WIDTH  = 8,
  parameter int                 P_WIDTH  = 64,
  parameter int                 TIMEOUT  = 1000,
  parameter int                 WAIT_MAX = 8,
  parameter logic [S_WIDTH-1:0] PAD      = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               byte_valid,
  input  logic [S_WIDTH-1:0]                 byte_data,
  output logic                               byte_ready,
  input  logic                               flush,
  output logic                               s2p_load,
  output logic [S_WIDTH-1:0]                 s2p_data,
  input  logic [P_WIDTH-1:0]                 s2p_word,
  input  logic                               s2p_valid,
  output logic [P_WIDTH-1:0]                 word_data,
  output logic [$clog2(P_WIDTH/S_WIDTH):0]   word_bytes,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic                               err_timeout
);

  localparam int N  = P_WIDTH / S_WIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);

  localparam logic [CW-1:0] N_CNT       = CW'(N);
  localparam logic [IW-1:0] TIMEOUT_CNT = IW'(TIMEOUT);
  localparam logic [WW-1:0] WAIT_CNT    = WW'(WAIT_MAX);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COLLECT   = 3'd1;
  localparam logic [2:0] ST_PAD       = 3'd2;
  localparam logic [2:0] ST_WAIT_WORD = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d, count_inc;
  logic [CW-1:0]      real_q, real_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic               flush_pend_q, flush_pend_d;
  logic               load_d;
  logic [S_WIDTH-1:0] data_d;
  logic [P_WIDTH-1:0] word_data_d;
  logic [CW-1:0]      word_bytes_d;
  logic               word_valid_d, err_d, byte_ready_d, accept;

  assign accept    = byte_valid && byte_ready;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    count_d      = count_q;
    real_d       = real_q;
    idle_d       = idle_q;
    wait_d       = wait_q;
    flush_pend_d = flush_pend_q;
    load_d       = 1'b0;
    data_d       = s2p_data;
    word_data_d  = word_data;
    word_bytes_d = word_bytes;
    word_valid_d = word_valid;
    err_d        = err_timeout;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_d       = 1'b1;
          data_d       = byte_data;
          count_d      = CW'(1);
          idle_d       = '0;
          flush_pend_d = 1'b0;
          state_d      = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (accept) begin
          load_d  = 1'b1;
          data_d  = byte_data;
          count_d = count_inc;
          idle_d  = '0;
          if (count_inc == N_CNT) begin
            real_d       = N_CNT;
            wait_d       = '0;
            flush_pend_d = 1'b0;
            state_d      = ST_WAIT_WORD;
          end else if (flush) begin
            // The byte wins this cycle; the flush is remembered for the next idle cycle.
            flush_pend_d = 1'b1;
          end
        end else if (idle_q == TIMEOUT_CNT || flush || flush_pend_q) begin
          // The pad decision edge also issues the first pad chunk.
          real_d       = count_q;
          load_d       = 1'b1;
          data_d       = PAD;
          count_d      = count_inc;
          flush_pend_d = 1'b0;
          wait_d       = '0;
          state_d      = (count_inc == N_CNT) ? ST_WAIT_WORD : ST_PAD;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      ST_PAD: begin
        load_d  = 1'b1;
        data_d  = PAD;
        count_d = count_inc;
        wait_d  = '0;
        if (count_inc == N_CNT) state_d = ST_WAIT_WORD;
      end

      ST_WAIT_WORD: begin
        // wait_q is 0 during the last-load cycle, so strobes land in L+1..L+WAIT_MAX.
        if (s2p_valid && wait_q != '0) begin
          word_data_d  = s2p_word;
          word_bytes_d = real_q;
          word_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end else if (wait_q == WAIT_CNT) begin
          err_d   = 1'b1;
          count_d = '0;
          idle_d  = '0;
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          count_d      = '0;
          idle_d       = '0;
          wait_d       = '0;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // byte_ready is registered from the next state so it reads 0 while reset is applied.
  assign byte_ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      real_q       <= '0;
      idle_q       <= '0;
      wait_q       <= '0;
      flush_pend_q <= 1'b0;
      byte_ready   <= 1'b0;
      s2p_load     <= 1'b0;
      s2p_data     <= '0;
      word_data    <= '0;
      word_bytes   <= '0;
      word_valid   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      real_q       <= real_d;
      idle_q       <= idle_d;
      wait_q       <= wait_d;
      flush_pend_q <= flush_pend_d;
      byte_ready   <= byte_ready_d;
      s2p_load     <= load_d;
      s2p_data     <= data_d;
      word_data    <= word_data_d;
      word_bytes   <= word_bytes_d;
      word_valid   <= word_valid_d;
      err_timeout  <= err_d;
    end
  end

endmodule
